// File: rtl/vehicle_data_receiver.sv
// Vehicle CAN data receiver: accepts AXI4-Stream CAN frames, extracts engine
// revolution and vehicle speed, and tracks per-channel freshness with timeouts.
module vehicle_data_receiver #(
    parameter int unsigned TIMEOUT_CYCLE = 150_000_000,
    parameter logic [10:0] ID_ENGINE_REV = 11'h3D9,
    parameter logic [10:0] ID_CAR_SPEED  = 11'h3E9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] stm_recv_data_in_tdata,
    input  logic [10:0] stm_recv_data_in_tid,
    input  logic [7:0]  stm_recv_data_in_tkeep,
    input  logic        stm_recv_data_in_tvalid,
    output logic        stm_recv_data_in_tready,
    output logic [13:0] engine_rev,
    output logic [8:0]  vehicle_speed,
    output logic        engine_rev_valid,
    output logic        vehicle_speed_valid,
    output logic        engine_rev_update,
    output logic        vehicle_speed_update,
    output logic [7:0]  error_count
);

    localparam int unsigned     CNT_W    = (TIMEOUT_CYCLE > 2) ? $clog2(TIMEOUT_CYCLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLE - 1);

    localparam logic [1:0] S_ACCEPT = 2'd0;
    localparam logic [1:0] S_CHECK  = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]       r_state;
    logic [10:0]      r_id;
    logic [1:0]       r_keep_eng;
    logic [1:0]       r_keep_spd;
    logic [13:0]      r_eng_field;
    logic [8:0]       r_spd_field;
    logic [13:0]      r_engine_rev;
    logic [8:0]       r_vehicle_speed;
    logic             r_eng_valid;
    logic             r_spd_valid;
    logic             r_eng_upd;
    logic             r_spd_upd;
    logic [7:0]       r_err;
    logic [CNT_W-1:0] r_eng_cnt;
    logic [CNT_W-1:0] r_spd_cnt;

    logic w_ready;
    logic w_hs;
    logic w_is_engine;
    logic w_is_speed;
    logic w_eng_commit;
    logic w_spd_commit;
    logic w_unused_bits;

    // Only the two payload fields and the qualifying keep bits are ever used.
    assign w_unused_bits = ^{stm_recv_data_in_tdata[54:48], stm_recv_data_in_tdata[33:0],
                             stm_recv_data_in_tkeep[3:0]};

    assign w_ready      = (r_state == S_ACCEPT) && !rst;
    assign w_hs         = stm_recv_data_in_tvalid && w_ready;
    assign w_is_engine  = (r_id == ID_ENGINE_REV) && (r_keep_eng == 2'b11);
    assign w_is_speed   = (r_id == ID_CAR_SPEED) && (r_keep_spd == 2'b11);
    assign w_eng_commit = (r_state == S_COMMIT) && w_is_engine;
    assign w_spd_commit = (r_state == S_COMMIT) && w_is_speed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_ACCEPT;
            r_id            <= '0;
            r_keep_eng      <= '0;
            r_keep_spd      <= '0;
            r_eng_field     <= '0;
            r_spd_field     <= '0;
            r_engine_rev    <= '0;
            r_vehicle_speed <= '0;
            r_eng_upd       <= 1'b0;
            r_spd_upd       <= 1'b0;
            r_err           <= '0;
        end else begin
            r_eng_upd <= w_eng_commit;
            r_spd_upd <= w_spd_commit;
            if (w_eng_commit) r_engine_rev    <= r_eng_field;
            if (w_spd_commit) r_vehicle_speed <= r_spd_field;
            case (r_state)
                S_ACCEPT: begin
                    if (w_hs) begin
                        r_id        <= stm_recv_data_in_tid;
                        r_keep_eng  <= stm_recv_data_in_tkeep[5:4];
                        r_keep_spd  <= stm_recv_data_in_tkeep[7:6];
                        r_eng_field <= stm_recv_data_in_tdata[47:34];
                        r_spd_field <= stm_recv_data_in_tdata[63:55];
                        r_state     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_is_engine || w_is_speed) begin
                        r_state <= S_COMMIT;
                    end else begin
                        r_state <= S_ACCEPT;
                        if (r_err != 8'hFF) r_err <= r_err + 8'd1;
                    end
                end
                S_COMMIT: r_state <= S_ACCEPT;
                default:  r_state <= S_ACCEPT;
            endcase
        end
    end

    // A commit takes priority over an expiring counter on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_eng_valid <= 1'b0;
            r_eng_cnt   <= '0;
        end else if (w_eng_commit) begin
            r_eng_valid <= 1'b1;
            r_eng_cnt   <= '0;
        end else if (r_eng_valid) begin
            if (r_eng_cnt == CNT_LAST) r_eng_valid <= 1'b0;
            else                       r_eng_cnt   <= r_eng_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_spd_valid <= 1'b0;
            r_spd_cnt   <= '0;
        end else if (w_spd_commit) begin
            r_spd_valid <= 1'b1;
            r_spd_cnt   <= '0;
        end else if (r_spd_valid) begin
            if (r_spd_cnt == CNT_LAST) r_spd_valid <= 1'b0;
            else                       r_spd_cnt   <= r_spd_cnt + 1'b1;
        end
    end

    assign stm_recv_data_in_tready = w_ready;
    assign engine_rev              = r_engine_rev;
    assign vehicle_speed           = r_vehicle_speed;
    assign engine_rev_valid        = r_eng_valid;
    assign vehicle_speed_valid     = r_spd_valid;
    assign engine_rev_update       = r_eng_upd;
    assign vehicle_speed_update    = r_spd_upd;
    assign error_count             = r_err;

endmodule

// File: tb/tb_vehicle_data_receiver.sv
// Testbench for vehicle_data_receiver: table vectors, directed corner cases and
// randomized traffic checked every cycle against a frame-level reference model.
module tb_vehicle_data_receiver;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] tdata = '0;
    logic [10:0] tid = '0;
    logic [7:0]  tkeep = '0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic [13:0] engine_rev;
    logic [8:0]  vehicle_speed;
    logic        engine_rev_valid, vehicle_speed_valid;
    logic        engine_rev_update, vehicle_speed_update;
    logic [7:0]  error_count;

    vehicle_data_receiver #(
        .TIMEOUT_CYCLE (TO),
        .ID_ENGINE_REV (11'h3D9),
        .ID_CAR_SPEED  (11'h3E9)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stm_recv_data_in_tdata  (tdata),
        .stm_recv_data_in_tid    (tid),
        .stm_recv_data_in_tkeep  (tkeep),
        .stm_recv_data_in_tvalid (tvalid),
        .stm_recv_data_in_tready (tready),
        .engine_rev              (engine_rev),
        .vehicle_speed           (vehicle_speed),
        .engine_rev_valid        (engine_rev_valid),
        .vehicle_speed_valid     (vehicle_speed_valid),
        .engine_rev_update       (engine_rev_update),
        .vehicle_speed_update    (vehicle_speed_update),
        .error_count             (error_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Edge index plus the bus inputs as seen on that edge
    int          edge_cnt = 0;
    logic        s_rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [10:0] s_id = '0;
    logic [7:0]  s_keep = '0;
    logic [63:0] s_data = '0;

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        s_rst    <= rst;
        s_valid  <= tvalid;
        s_id     <= tid;
        s_keep   <= tkeep;
        s_data   <= tdata;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_cnt, act, exp);
        end
    endtask

    // 1 = engine frame, 2 = speed frame, 3 = dropped
    function automatic int kind_of(input logic [10:0] id, input logic [7:0] keep);
        if (id == 11'h3D9 && keep[5] && keep[4]) return 1;
        if (id == 11'h3E9 && keep[7] && keep[6]) return 2;
        return 3;
    endfunction

    // Reference model: frame outcomes scheduled by edge number; freshness derived
    // from the edge of the last commit on each channel.
    int          m_err = 0;
    logic [13:0] m_eng = '0;
    logic [8:0]  m_spd = '0;
    bit          m_eng_has = 0, m_spd_has = 0;
    int          m_eng_t = 0, m_spd_t = 0;
    int          ready_from = 0;
    int          p_kind = 0, p_at = 0;
    logic [13:0] p_val = '0;

    initial begin
        int e;
        forever begin
            @(negedge clk);
            e = edge_cnt;
            if (e > 0) begin
                if (s_rst) begin
                    m_err = 0; m_eng = '0; m_spd = '0;
                    m_eng_has = 0; m_spd_has = 0;
                    p_kind = 0; ready_from = e + 1;
                end else begin
                    if (p_kind != 0 && p_at == e) begin
                        case (p_kind)
                            1: begin m_eng = p_val; m_eng_has = 1; m_eng_t = e; end
                            2: begin m_spd = p_val[8:0]; m_spd_has = 1; m_spd_t = e; end
                            default: if (m_err < 255) m_err++;
                        endcase
                        p_kind = 0;
                    end
                    if (s_valid && e >= ready_from) begin
                        p_kind = kind_of(s_id, s_keep);
                        if (p_kind == 1) p_val = s_data[47:34];
                        else             p_val = {5'd0, s_data[63:55]};
                        p_at       = (p_kind == 3) ? e + 1 : e + 2;
                        ready_from = (p_kind == 3) ? e + 2 : e + 3;
                    end
                end
                check("m_tready", tready, 64'(!rst && (e + 1 >= ready_from)));
                check("m_engine_rev", engine_rev, m_eng);
                check("m_vehicle_speed", vehicle_speed, m_spd);
                check("m_engine_valid", engine_rev_valid, 64'(m_eng_has && (e - m_eng_t) < TO));
                check("m_speed_valid", vehicle_speed_valid, 64'(m_spd_has && (e - m_spd_t) < TO));
                check("m_engine_update", engine_rev_update, 64'(m_eng_has && m_eng_t == e));
                check("m_speed_update", vehicle_speed_update, 64'(m_spd_has && m_spd_t == e));
                check("m_error_count", error_count, 64'(m_err));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents a frame and holds it until accepted; returns the handshake edge.
    task automatic send(input logic [10:0] id, input logic [63:0] d, input logic [7:0] k,
                        output int hs);
        logic rdy;
        int   tries;
        tid = id; tdata = d; tkeep = k; tvalid = 1'b1;
        hs = -1; tries = 0;
        while (hs < 0 && tries < 20) begin
            @(negedge clk);
            rdy = tready;
            @(posedge clk);
            #1;
            if (rdy) hs = edge_cnt;
            tries++;
        end
        tvalid = 1'b0;
        if (hs < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL handshake_timeout: got no tready in 20 cycles expected handshake");
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [10:0] id;
        logic [63:0] data;
        logic [7:0]  keep;
        logic [13:0] eng;
        logic [8:0]  spd;
        logic [7:0]  err;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, hs2, e0;
        vecs[0] = '{11'h3D9, {16'd0, 14'd3000, 34'd0}, 8'hFF, 14'd3000,  9'd0,   8'd0};
        vecs[1] = '{11'h3E9, {9'd120, 55'd0},          8'hFF, 14'd3000,  9'd120, 8'd0};
        vecs[2] = '{11'h3D9, {16'd0, 14'd5, 34'd0},    8'h0F, 14'd3000,  9'd120, 8'd1};
        vecs[3] = '{11'h3E9, {9'd7, 55'd0},            8'h7F, 14'd3000,  9'd120, 8'd2};
        vecs[4] = '{11'h3D9, 64'hFFFF_FFFF_FFFF_FFFF,  8'h30, 14'd16383, 9'd120, 8'd2};
        vecs[5] = '{11'h3E9, 64'hFF80_0000_0000_0000,  8'hC0, 14'd16383, 9'd511, 8'd2};
        vecs[6] = '{11'h123, 64'hFFFF_FFFF_FFFF_FFFF,  8'hFF, 14'd16383, 9'd511, 8'd3};
        vecs[7] = '{11'h3D9, 64'hFFFF_0003_FFFF_FFFF,  8'hFF, 14'd0,     9'd511, 8'd3};
        vecs[8] = '{11'h3E9, 64'h007F_FFFF_FFFF_FFFF,  8'hFF, 14'd0,     9'd0,   8'd3};
        vecs[9] = '{11'h3D9, {16'd0, 14'd9, 34'd0},    8'h10, 14'd0,     9'd0,   8'd4};

        // Reset state and first-cycle acceptance
        idle(3);
        check("rst_tready_low", tready, 0);
        check("rst_error_count", error_count, 0);
        check("rst_engine_rev", engine_rev, 0);
        check("rst_speed_valid", vehicle_speed_valid, 0);
        rst = 1'b0;
        #1;
        check("rst_tready_first", tready, 1);

        for (int i = 0; i < 10; i++) begin
            send(vecs[i].id, vecs[i].data, vecs[i].keep, hs);
            idle(3);
            check($sformatf("vec%0d_engine_rev", i), engine_rev, vecs[i].eng);
            check($sformatf("vec%0d_speed", i), vehicle_speed, vecs[i].spd);
            check($sformatf("vec%0d_error_count", i), error_count, vecs[i].err);
        end

        // Reset one cycle after an engine handshake discards the frame
        send(11'h3D9, {16'd0, 14'd3000, 34'd0}, 8'hFF, hs);
        rst = 1'b1;
        #1;
        check("midrst_tready_low", tready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_tready_first", tready, 1);
        idle(4);
        check("midrst_engine_rev", engine_rev, 0);
        check("midrst_speed", vehicle_speed, 0);
        check("midrst_error_count", error_count, 0);
        check("midrst_engine_valid", engine_rev_valid, 0);

        // Timeout: speed valid falls 16 edges after the commit edge, value held
        do_reset();
        send(11'h3E9, {9'd120, 55'd0}, 8'hFF, hs);
        e0 = hs + 2;
        idle(e0 + 15 - edge_cnt);
        check("to_valid_before", vehicle_speed_valid, 1);
        idle(1);
        check("to_valid_after", vehicle_speed_valid, 0);
        check("to_value_held", vehicle_speed, 120);
        idle(5);
        check("to_still_stale", vehicle_speed_valid, 0);
        check("to_engine_never", engine_rev_valid, 0);

        // Commit coinciding with the last counter cycle keeps the channel fresh
        do_reset();
        send(11'h3E9, {9'd120, 55'd0}, 8'hFF, hs);
        e0 = hs + 2;
        idle(e0 + 13 - edge_cnt);
        send(11'h3E9, {9'd200, 55'd0}, 8'hFF, hs2);
        check("race_hs_edge", hs2, e0 + 14);
        idle(2);
        check("race_valid", vehicle_speed_valid, 1);
        check("race_update", vehicle_speed_update, 1);
        check("race_value", vehicle_speed, 200);
        idle(15);
        check("race_valid_restart", vehicle_speed_valid, 1);
        idle(1);
        check("race_valid_expire", vehicle_speed_valid, 0);

        // 300 unknown-ID frames saturate the error counter
        do_reset();
        for (int i = 0; i < 300; i++) send(11'h123, 64'h0123_4567_89AB_CDEF, 8'hFF, hs);
        idle(2);
        check("sat_error_count", error_count, 255);

        // Randomized traffic, gaps long enough to exercise timeouts
        do_reset();
        for (int i = 0; i < 200; i++) begin
            logic [10:0] rid;
            logic [7:0]  rkeep;
            case ($urandom_range(0, 3))
                0, 3:    rid = 11'h3D9;
                1:       rid = 11'h3E9;
                default: rid = 11'($urandom);
            endcase
            rkeep = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            send(rid, {$urandom, $urandom}, rkeep, hs);
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                idle(1);
                rst = 1'b0;
            end
            tdata = {$urandom, $urandom};
            idle($urandom_range(0, 3) == 0 ? $urandom_range(10, 24) : $urandom_range(0, 3));
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
